// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a DEPTH x 32-bit memory array.
// The read engine serves INCR bursts that wrap at DEPTH; the write engine accepts single beats with byte strobes.
module axi_sram_slave #(
    parameter int ADDR_WIDTH = 10,
    parameter int INIT_ZERO  = 1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [3:0]  S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [2:0]  S_AXI_ARSIZE,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [3:0]  S_AXI_RID,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWSIZE,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_BURST     = 1'b1;

    localparam logic [1:0] W_IDLE      = 2'd0;
    localparam logic [1:0] W_WAIT_DATA = 2'd1;
    localparam logic [1:0] W_WAIT_ADDR = 2'd2;
    localparam logic [1:0] W_RESP      = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // Time-zero contents are simulation-only; reset never touches the array.
    logic [31:0] mem_r [0:DEPTH-1] = '{default: ((INIT_ZERO != 0) ? 32'h0000_0000 : 32'hxxxx_xxxx)};

    logic [0:0]            r_state_r;
    logic [7:0]            r_cnt_r;
    logic [ADDR_WIDTH-1:0] r_idx_r;
    logic [31:0]           rdata_r;
    logic [3:0]            rid_r;
    logic [ADDR_WIDTH-1:0] ar_idx_s;
    logic                  ar_hs_s;
    logic                  r_hs_s;

    logic [1:0]            w_state_r;
    logic [1:0]            w_state_nxt_s;
    logic [ADDR_WIDTH-1:0] aw_idx_r;
    logic [31:0]           wdata_r;
    logic [3:0]            wstrb_r;
    logic [ADDR_WIDTH-1:0] aw_idx_s;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  we_s;
    logic                  lat_aw_s;
    logic                  lat_w_s;
    logic [ADDR_WIDTH-1:0] w_idx_s;
    logic [31:0]           w_data_s;
    logic [3:0]            w_strb_s;

    logic                  unused_s;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign ar_idx_s = S_AXI_ARADDR[ADDR_WIDTH+1:2];
    assign aw_idx_s = S_AXI_AWADDR[ADDR_WIDTH+1:2];

    assign S_AXI_ARREADY = (r_state_r == R_IDLE);
    assign S_AXI_RVALID  = (r_state_r == R_BURST);
    assign S_AXI_RLAST   = (r_state_r == R_BURST) && (r_cnt_r == 8'd0);
    assign S_AXI_RID     = rid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;

    assign S_AXI_AWREADY = (w_state_r == W_IDLE) || (w_state_r == W_WAIT_ADDR);
    assign S_AXI_WREADY  = (w_state_r == W_IDLE) || (w_state_r == W_WAIT_DATA);
    assign S_AXI_BVALID  = (w_state_r == W_RESP);
    assign S_AXI_BRESP   = 2'b00;

    assign ar_hs_s = S_AXI_ARVALID & S_AXI_ARREADY;
    assign r_hs_s  = S_AXI_RVALID & S_AXI_RREADY;
    assign aw_hs_s = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs_s  = S_AXI_WVALID & S_AXI_WREADY;

    assign unused_s = ^{S_AXI_ARSIZE, S_AXI_AWSIZE,
                        S_AXI_ARADDR[31:ADDR_WIDTH+2], S_AXI_ARADDR[1:0],
                        S_AXI_AWADDR[31:ADDR_WIDTH+2], S_AXI_AWADDR[1:0]};

    // Read engine: the memory read for the next beat is issued on each handshake, so beats stream without bubbles.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state_r <= R_IDLE;
            r_cnt_r   <= 8'd0;
            r_idx_r   <= {ADDR_WIDTH{1'b0}};
            rdata_r   <= 32'h0000_0000;
            rid_r     <= 4'h0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rid_r     <= S_AXI_ARID;
                        r_cnt_r   <= S_AXI_ARLEN;
                        rdata_r   <= mem_r[ar_idx_s];
                        r_idx_r   <= ar_idx_s + IDX_ONE;
                        r_state_r <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (r_hs_s) begin
                        if (r_cnt_r == 8'd0) begin
                            r_state_r <= R_IDLE;
                        end else begin
                            r_cnt_r <= r_cnt_r - 8'd1;
                            rdata_r <= mem_r[r_idx_r];
                            r_idx_r <= r_idx_r + IDX_ONE;
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    // Write engine next-state and write-port selection; the half that arrived first comes from the latches.
    always_comb begin
        w_state_nxt_s = w_state_r;
        we_s          = 1'b0;
        lat_aw_s      = 1'b0;
        lat_w_s       = 1'b0;
        w_idx_s       = aw_idx_r;
        w_data_s      = wdata_r;
        w_strb_s      = wstrb_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    we_s          = 1'b1;
                    w_idx_s       = aw_idx_s;
                    w_data_s      = S_AXI_WDATA;
                    w_strb_s      = S_AXI_WSTRB;
                    w_state_nxt_s = W_RESP;
                end else if (aw_hs_s) begin
                    lat_aw_s      = 1'b1;
                    w_state_nxt_s = W_WAIT_DATA;
                end else if (w_hs_s) begin
                    lat_w_s       = 1'b1;
                    w_state_nxt_s = W_WAIT_ADDR;
                end else begin
                    w_state_nxt_s = W_IDLE;
                end
            end
            W_WAIT_DATA: begin
                if (w_hs_s) begin
                    we_s          = 1'b1;
                    w_data_s      = S_AXI_WDATA;
                    w_strb_s      = S_AXI_WSTRB;
                    w_state_nxt_s = W_RESP;
                end else begin
                    w_state_nxt_s = W_WAIT_DATA;
                end
            end
            W_WAIT_ADDR: begin
                if (aw_hs_s) begin
                    we_s          = 1'b1;
                    w_idx_s       = aw_idx_s;
                    w_state_nxt_s = W_RESP;
                end else begin
                    w_state_nxt_s = W_WAIT_ADDR;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_nxt_s = W_IDLE;
                end else begin
                    w_state_nxt_s = W_RESP;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
            end
        endcase
    end

    // Write engine state and the latches holding whichever half of a write arrived first.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state_r <= W_IDLE;
            aw_idx_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
        end else begin
            w_state_r <= w_state_nxt_s;
            if (lat_aw_s) begin
                aw_idx_r <= aw_idx_s;
            end
            if (lat_w_s) begin
                wdata_r <= S_AXI_WDATA;
                wstrb_r <= S_AXI_WSTRB;
            end
        end
    end

    // Memory write port; a read of the same word in this cycle still sees the old contents.
    always_ff @(posedge S_AXI_ACLK) begin
        if (we_s && S_AXI_ARESETN) begin
            mem_r[w_idx_s] <= byte_merge(mem_r[w_idx_s], w_data_s, w_strb_s);
        end
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: word-address bits, DEPTH = 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter INIT_ZERO, default 1: 1 = memory array cleared to 0 at time zero (simulation); 0 = uninitialised.
REQ-003 SHALL have port S_AXI_ACLK, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have read-address ports: S_AXI_ARID in 4; S_AXI_ARADDR in 32; S_AXI_ARLEN in 8; S_AXI_ARSIZE in 3; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-006 SHALL have read-data ports: S_AXI_RID out 4; S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RLAST out 1; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-007 SHALL have write-address ports: S_AXI_AWADDR in 32; S_AXI_AWSIZE in 3; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-008 SHALL have write-data ports: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-009 SHALL have write-response ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.

Function
REQ-010 SHALL decode word index = ADDR[ADDR_WIDTH+1:2]; bits above and ADDR[1:0] ignored; ARSIZE/AWSIZE ignored, 32-bit beats only.
REQ-011 SHALL drive RRESP = BRESP = 2'b00 at all times.
REQ-012 SHALL run read FSM states R_IDLE, R_BURST; ARREADY = 1 only in R_IDLE.
REQ-013 SHALL, on AR handshake in R_IDLE: latch ARID into RID, load beat counter = ARLEN, load RDATA register with mem[index], set index_next = index+1, enter R_BURST; RVALID asserts the next cycle (1-cycle latency).
REQ-014 SHALL hold RVALID, RDATA, RID, RLAST stable in R_BURST until RVALID & RREADY.
REQ-015 SHALL assert RLAST combinationally when in R_BURST and beat counter == 0.
REQ-016 SHALL, on R handshake with counter != 0: decrement counter, load RDATA from mem[index_next], increment index_next, stay in R_BURST (back-to-back beats, no bubble).
REQ-017 SHALL, on R handshake with RLAST: return to R_IDLE, deassert RVALID; next AR accepted no earlier than the following cycle.
REQ-018 SHALL wrap index increment modulo DEPTH (DEPTH-1 -> 0); ARLEN 255 yields 256 beats.
REQ-019 SHALL run write FSM states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP; single-beat writes only (no AWLEN/WLAST).
REQ-020 SHALL drive AWREADY = 1 in W_IDLE and W_WAIT_ADDR; WREADY = 1 in W_IDLE and W_WAIT_DATA; BVALID = 1 only in W_RESP.
REQ-021 SHALL, in W_IDLE: AW and W both handshaken same cycle -> write, go W_RESP; AW only -> latch address, go W_WAIT_DATA; W only -> latch WDATA/WSTRB, go W_WAIT_ADDR.
REQ-022 SHALL, in W_WAIT_DATA on W handshake or W_WAIT_ADDR on AW handshake: perform write, go W_RESP.
REQ-023 SHALL perform write as byte-lane update: byte i of mem[index] written only when WSTRB[i]=1; WSTRB=0 still produces BVALID.
REQ-024 SHALL, in W_RESP, hold BVALID until BREADY, then go W_IDLE; BVALID may assert with BREADY already high and handshake in one cycle.
REQ-025 SHALL run read and write FSMs independently and concurrently.
REQ-026 SHALL, on same-cycle write and RDATA load to the same word, load the pre-write (old) data.

Reset
REQ-027 SHALL, while S_AXI_ARESETN = 0, asynchronously force: FSMs to R_IDLE/W_IDLE, RVALID=0, BVALID=0, RLAST=0, RID=0, RDATA=0, counter=0; ARREADY=1, AWREADY=1, WREADY=1 combinationally from state.
REQ-028 SHALL abandon any in-flight burst or half-received write on reset, with no response issued afterwards; memory contents retained.
REQ-029 SHALL resume handshakes on the first rising edge after reset deasserts.

Verification
REQ-030 Write AW=0x10/W=0xDEADBEEF/WSTRB=F same cycle, BREADY=1 -> BVALID 1 cycle later; read ARADDR=0x10 ARLEN=0 ARID=5 -> RDATA=0xDEADBEEF, RID=5, RLAST=1 one cycle after AR handshake.
REQ-031 W 0x11223344 two cycles before AW 0x20, WSTRB=4'b0101 over prior 0xAAAAAAAA -> mem[8]=0xAA22AA44, one BVALID.
REQ-032 Burst ARADDR=(DEPTH-2)*4, ARLEN=3, RREADY toggling 1/0 -> 4 beats from words DEPTH-2, DEPTH-1, 0, 1; RLAST only on beat 4; data stable while RREADY=0.
REQ-033 BREADY held 0 for 5 cycles -> BVALID stays 1, AWREADY/WREADY stay 0; new AW accepted cycle after B handshake.
REQ-034 Reset asserted mid-burst (beat 2 of 8) -> RVALID=0 immediately, ARREADY=1; after release new AR served with correct data.
REQ-035 Concurrent 16-beat read and 16 writes to disjoint addresses -> all data correct, no stall of either channel.
